// File: rtl/reduce_vector.sv
// reduce_vector
//   Sequential reducer. It collapses one vector of N_ELEM signed 32-bit lanes
//   into a single 32-bit scalar and processes one lane per clock.
//   op=0 gives a wrap-around two's-complement sum.
//   op=1 gives the signed maximum; on a tie the earlier lane is kept.
//
// Ports
//   clk     : system clock; all state changes occur on the rising edge.
//   rst_n   : synchronous active-low reset.
//   start   : request pulse. It is accepted only while busy=0.
//   op      : operation select (0 = sum, 1 = max). Captured at accept.
//   length  : number of active lanes counted from lane 0. Values above
//             N_ELEM are clamped to N_ELEM. Captured at accept.
//   vector  : operand lanes. The whole vector is captured at accept.
//   scalar  : reduction result. It holds the last result until the next done.
//   busy    : high from accept until the done cycle, inclusive.
//   done    : one-cycle pulse. scalar is valid during that cycle.

`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

module reduce_vector #(
    parameter int unsigned N_ELEM = `MAX_NEURONS,
    parameter int unsigned LEN_W  = $clog2(N_ELEM + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     op,
    input  logic [LEN_W-1:0]         length,
    input  logic [N_ELEM-1:0][31:0]  vector,
    output logic signed [31:0]       scalar,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [N_ELEM-1:0][31:0]   vec_q;
    logic                      op_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          idx_q;
    logic [31:0]               acc_q;
    logic [31:0]               acc_nxt;
    logic [31:0]               lane;
    logic [LEN_W-1:0]          len_clamp;
    logic                      last;

    // A length larger than the lane count reduces the whole vector.
    always_comb begin
        len_clamp = length;
        if (length > LEN_W'(N_ELEM)) begin
            len_clamp = LEN_W'(N_ELEM);
        end
    end

    // idx_q never reaches N_ELEM while in ACCUM, so the narrower index is safe.
    always_comb begin
        lane    = vec_q[idx_q[IDX_W-1:0]];
        acc_nxt = acc_q + lane;
        if (op_q) begin
            acc_nxt = ($signed(lane) > $signed(acc_q)) ? lane : acc_q;
        end
    end

    assign last = (idx_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamp == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q  <= '0;
            op_q   <= 1'b0;
            len_q  <= '0;
            idx_q  <= '0;
            acc_q  <= '0;
            scalar <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_q <= vector;
                        op_q  <= op;
                        len_q <= len_clamp;
                        idx_q <= '0;
                        // The max accumulator starts at the most negative value,
                        // so that lane 0 always replaces it.
                        acc_q <= op ? 32'h8000_0000 : 32'h0000_0000;
                        if (len_clamp == '0) begin
                            scalar <= '0;
                        end
                    end
                end
                ACCUM: begin
                    acc_q <= acc_nxt;
                    idx_q <= idx_q + LEN_W'(1);
                    if (last) begin
                        scalar <= acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_reduce_vector.sv
// Directed testbench for reduce_vector with N_ELEM=8.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge. A latency of k means that done was observed k falling edges
// after the rising edge that accepted start.

module tb_reduce_vector;

    localparam int unsigned N     = 8;
    localparam int unsigned LEN_W = $clog2(N + 1);

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  op;
    logic [LEN_W-1:0]      length;
    logic [N-1:0][31:0]    vector;
    logic signed [31:0]    scalar;
    logic                  busy;
    logic                  done;

    int tests = 0;
    int fails = 0;

    reduce_vector #(.N_ELEM(N), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .length (length),
        .vector (vector),
        .scalar (scalar),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only. It launches one request and waits a bounded number of
    // cycles for done. On timeout, lat stays -1.
    task automatic run_op(input logic o, input int l, input logic [N-1:0][31:0] v,
                          input bit scramble, output logic [31:0] res,
                          output int lat, output int busy_n, output bit moved);
        logic [31:0] s0;
        @(negedge clk);
        op = o; length = LEN_W'(l); vector = v; start = 1'b1;
        s0 = scalar; res = 'x; lat = -1; busy_n = 0; moved = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                if (scramble) vector = {N{32'h0000_0007}};
            end
            if (busy) busy_n++;
            if (done) begin
                lat = k; res = scalar;
                break;
            end
            if (scalar !== s0) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; length = '0; vector = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (scalar !== 32'sd0) begin fails++; $display("FAIL reset_scalar: got %0h expected 0", scalar); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_sum_basic();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv;
        for (int i = 0; i < int'(N); i++) v[i] = 32'(i + 1);
        run_op(1'b0, 4, v, 1'b0, r, lat, bn, mv);
        tests++; if (r !== 32'd10) begin fails++; $display("FAIL sum_basic_value: got %0d expected 10", $signed(r)); end
        tests++; if (lat != 5) begin fails++; $display("FAIL sum_basic_latency: got %0d expected 5", lat); end
        tests++; if (bn != 5) begin fails++; $display("FAIL sum_basic_busy_cycles: got %0d expected 5", bn); end
        tests++; if (mv) begin fails++; $display("FAIL sum_basic_scalar_hold: got changed expected stable"); end
        @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL sum_basic_single_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_max_neg();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv;
        v = '0;
        v[0] = -32'sd5; v[1] = -32'sd2; v[2] = -32'sd9; v[3] = -32'sd2; v[4] = 32'd100;
        run_op(1'b1, 4, v, 1'b0, r, lat, bn, mv);
        tests++; if (r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL max_neg_value: got %0d expected -2", $signed(r)); end
        tests++; if (lat != 5) begin fails++; $display("FAIL max_neg_latency: got %0d expected 5", lat); end
        run_op(1'b1, 5, v, 1'b0, r, lat, bn, mv);
        tests++; if (r !== 32'd100) begin fails++; $display("FAIL max_len5_value: got %0d expected 100", $signed(r)); end
    endtask

    task automatic test_zero_len();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv;
        v = {N{32'h0000_0033}};
        for (int o = 0; o < 2; o++) begin
            run_op(o[0], 0, v, 1'b0, r, lat, bn, mv);
            tests++; if (r !== 32'd0) begin fails++; $display("FAIL zero_len_value op=%0d: got %0h expected 0", o, r); end
            tests++; if (lat != 1) begin fails++; $display("FAIL zero_len_latency op=%0d: got %0d expected 1", o, lat); end
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv;
        v = {N{32'h0000_0005}};
        v[0] = 32'h7FFF_FFFF; v[1] = 32'h0000_0001;
        run_op(1'b0, 2, v, 1'b0, r, lat, bn, mv);
        tests++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL overflow_wrap: got %0h expected 80000000", r); end
        tests++; if (lat != 3) begin fails++; $display("FAIL overflow_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_clamp_capture();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv;
        v = {N{32'h0000_0001}};
        run_op(1'b0, int'(N) + 5, v, 1'b1, r, lat, bn, mv);
        tests++; if (r !== 32'd8) begin fails++; $display("FAIL clamp_capture_value: got %0d expected 8", $signed(r)); end
        tests++; if (lat != 9) begin fails++; $display("FAIL clamp_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_back_to_back();
        int pulses; int lat; logic [31:0] r;
        pulses = 0; lat = -1; r = 'x;
        @(negedge clk);
        vector = '0; vector[0] = 32'd10; vector[1] = 32'd20; vector[2] = 32'd30;
        op = 1'b0; length = LEN_W'(3); start = 1'b1;
        @(negedge clk);
        // Collision request while the first reduction is in ACCUM.
        vector = {N{32'd1000}}; length = LEN_W'(1); op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin pulses++; r = scalar; break; end
            @(negedge clk);
        end
        tests++; if (r !== 32'd60) begin fails++; $display("FAIL collision_first_value: got %0d expected 60", $signed(r)); end
        // Collision request during the DONE cycle.
        start = 1'b1; vector = {N{32'd1000}}; length = LEN_W'(1);
        @(negedge clk);
        if (done) pulses++;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL collision_done_ignored: got busy=%b done=%b expected 0 0", busy, done);
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL collision_pulse_count: got %0d expected 1", pulses); end
        // A start in the cycle after done is accepted.
        vector = '0; vector[0] = 32'd5; vector[1] = 32'd6; length = LEN_W'(2); op = 1'b0; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin lat = k; r = scalar; break; end
        end
        tests++; if (r !== 32'd11) begin fails++; $display("FAIL back_to_back_value: got %0d expected 11", $signed(r)); end
        tests++; if (lat != 3) begin fails++; $display("FAIL back_to_back_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0][31:0] v; logic [31:0] r; int lat, bn; bit mv; int pulses;
        pulses = 0;
        @(negedge clk);
        for (int i = 0; i < int'(N); i++) v[i] = 32'(i + 1);
        vector = v; op = 1'b0; length = LEN_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_mid_precondition: got busy=%b expected 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (scalar !== 32'sd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_mid_state: got scalar=%0h busy=%b done=%b expected 0 0 0", scalar, busy, done);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", pulses); end
        v = '0; v[0] = 32'd4; v[1] = 32'd4; v[2] = 32'd4; v[3] = 32'd50;
        run_op(1'b0, 3, v, 1'b0, r, lat, bn, mv);
        tests++; if (r !== 32'd12) begin fails++; $display("FAIL reset_mid_after_value: got %0d expected 12", $signed(r)); end
    endtask

    initial begin
        test_reset();
        test_sum_basic();
        test_max_neg();
        test_zero_len();
        test_overflow();
        test_clamp_capture();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
